// File: rtl/hazard_flush_ctrl_pkg.sv
// hfc_pkg: shared types and constants for the decode-stage sequencing
// controller and its helpers.
//   state_t   - controller FSM states
//   OP_*      - 5-bit opcodes (fd_instr[15:11]) that matter for source usage
//   NOP_INSTR - instruction word decode substitutes while flushing
package hfc_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        LDSTALL = 3'd1,
        FL2     = 3'd2,
        FL3     = 3'd3,
        HALTED  = 3'd4
    } state_t;

    localparam logic [4:0] OP_HALT     = 5'b00000;
    localparam logic [4:0] OP_NOP      = 5'b00001;
    localparam logic [4:0] OP_J        = 5'b00100;
    localparam logic [4:0] OP_JAL      = 5'b00110;
    localparam logic [4:0] OP_ST       = 5'b10000;
    localparam logic [4:0] OP_STU      = 5'b10011;
    localparam logic [4:0] OP_LBI      = 5'b11000;
    // R-type ALU group: shifts/rotates, add/sub/xor/andn, and the set ops
    localparam logic [4:0] OP_R_SHIFT  = 5'b11010;
    localparam logic [4:0] OP_R_ARITH  = 5'b11011;
    localparam logic [4:0] OP_R_SEQ    = 5'b11100;
    localparam logic [4:0] OP_R_SLT    = 5'b11101;
    localparam logic [4:0] OP_R_SLE    = 5'b11110;
    localparam logic [4:0] OP_R_SCO    = 5'b11111;

    localparam logic [15:0] NOP_INSTR  = 16'h0800;

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// hazard_flush_ctrl_if: pipeline-side signals of the decode sequencing
// controller.
//   master - pipeline: drives decode/execute status, receives controls
//   slave  - controller: reads status, drives pc_en/fd_en/dx_en, dx_bubble,
//            the three flush strobes and halted
interface hazard_flush_ctrl_if;
    import hfc_pkg::*;

    logic [15:0] fd_instr;
    logic        fd_valid;
    logic        dx_memRead;
    logic        dx_regWrite;
    logic [2:0]  dx_writeReg;
    logic        mispredict;
    logic        mem_stall;
    logic        pc_en;
    logic        fd_en;
    logic        dx_en;
    logic        dx_bubble;
    logic        flush;
    logic        flush_again;
    logic        flush_final;
    logic        halted;

    modport master (
        output fd_instr, fd_valid, dx_memRead, dx_regWrite, dx_writeReg,
               mispredict, mem_stall,
        input  pc_en, fd_en, dx_en, dx_bubble, flush, flush_again,
               flush_final, halted
    );

    modport slave (
        input  fd_instr, fd_valid, dx_memRead, dx_regWrite, dx_writeReg,
               mispredict, mem_stall,
        output pc_en, fd_en, dx_en, dx_bubble, flush, flush_again,
               flush_final, halted
    );

endinterface

// File: rtl/hazard_flush_ctrl_src_use_dec.sv
// src_use_dec: opcode -> which register source fields the instruction reads.
//   opcode  in  5  fd_instr[15:11]
//   uses_rs out 1  instruction reads rs (fd_instr[10:8])
//   uses_rt out 1  instruction reads rt (fd_instr[7:5])
module src_use_dec
    import hfc_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       uses_rs,
    output logic       uses_rt
);

    assign uses_rs = !(opcode inside {OP_HALT, OP_NOP, OP_J, OP_JAL, OP_LBI});

    // Stores read their data register through the rt field
    assign uses_rt = opcode inside {OP_R_SHIFT, OP_R_ARITH, OP_R_SEQ, OP_R_SLT,
                                    OP_R_SLE, OP_R_SCO, OP_ST, OP_STU};

endmodule

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: stall/bubble/flush sequencing around the decode stage.
//   clk, rst   - clock and synchronous active-high reset
//   bus.slave  - decode/execute status in; pc_en, fd_en, dx_en, dx_bubble,
//                flush/flush_again/flush_final and halted out
//   LD_BUBBLES - bubbles inserted per load-use hazard (1..3)
module hazard_flush_ctrl
    import hfc_pkg::*;
#(
    parameter int unsigned LD_BUBBLES = 1
)
(
    input  logic               clk,
    input  logic               rst,
    hazard_flush_ctrl_if.slave bus
);

    // The hazard cycle itself is the first bubble; LDSTALL covers the rest
    localparam logic [1:0] CNT_LOAD = (LD_BUBBLES > 1) ? 2'(LD_BUBBLES - 2) : 2'd0;

    state_t     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic       uses_rs, uses_rt;
    logic       hz, halt_dec;
    logic [4:0] unused_fd_low;

    assign unused_fd_low = bus.fd_instr[4:0];

    src_use_dec u_src_use_dec (
        .opcode  (bus.fd_instr[15:11]),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt)
    );

    assign hz = bus.fd_valid & bus.dx_memRead & bus.dx_regWrite &
                ((uses_rs & (bus.fd_instr[10:8] == bus.dx_writeReg)) |
                 (uses_rt & (bus.fd_instr[7:5]  == bus.dx_writeReg)));

    assign halt_dec = bus.fd_valid & (bus.fd_instr[15:11] == OP_HALT);

    always_comb begin
        bus.pc_en       = 1'b1;
        bus.fd_en       = 1'b1;
        bus.dx_en       = 1'b1;
        bus.dx_bubble   = 1'b0;
        bus.flush       = 1'b0;
        bus.flush_again = 1'b0;
        bus.flush_final = 1'b0;
        bus.halted      = 1'b0;
        state_n         = state;
        cnt_n           = cnt;
        if (!rst) begin
            bus.flush_again = (state == FL2);
            bus.flush_final = (state == FL3);
            bus.halted      = (state == HALTED);
            if (bus.mem_stall) begin
                // Whole front end frozen; a pending mispredict re-presents later
                bus.pc_en = 1'b0;
                bus.fd_en = 1'b0;
                bus.dx_en = 1'b0;
            end else begin
                unique case (state)
                    RUN: begin
                        if (bus.mispredict) begin
                            bus.flush = 1'b1;
                            state_n   = FL2;
                        end else if (halt_dec) begin
                            state_n = HALTED;
                        end else if (hz) begin
                            bus.pc_en     = 1'b0;
                            bus.fd_en     = 1'b0;
                            bus.dx_bubble = 1'b1;
                            if (LD_BUBBLES > 1) begin
                                state_n = LDSTALL;
                                cnt_n   = CNT_LOAD;
                            end
                        end
                    end
                    LDSTALL: begin
                        bus.pc_en     = 1'b0;
                        bus.fd_en     = 1'b0;
                        bus.dx_bubble = 1'b1;
                        if (cnt == 2'd0) state_n = RUN;
                        else             cnt_n   = cnt - 2'd1;
                    end
                    FL2: state_n = FL3;
                    FL3: state_n = RUN;
                    HALTED: begin
                        bus.pc_en     = 1'b0;
                        bus.fd_en     = 1'b0;
                        bus.dx_bubble = 1'b1;
                    end
                    default: state_n = RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Execute holds a bubble during LDSTALL, so no branch can resolve there
    always_ff @(posedge clk) begin
        if (!rst && !bus.mem_stall)
            assert (!(state == LDSTALL && bus.mispredict));
    end

endmodule
